// File: rtl/dadda_mac_accumulator.sv
// Burst multiply-accumulate: registered operands -> Dadda 4x4 array -> registered product -> accumulator.
// Result is held behind a valid/ready handshake until the consumer takes it.
module dadda_mac_accumulator #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1_v;
  logic [3:0]       r_s1_a;
  logic [3:0]       r_s1_b;
  logic             r_s2_v;
  logic [7:0]       r_s2_p;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_prod;
  logic [3:0]       w_pp [4];

  assign in_ready  = (r_state == StRun);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

  assign w_accept  = in_valid && in_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // Extra top bit of the sum is the carry-out that feeds the sticky overflow flag.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, r_s2_p};

  // Partial products: w_pp[i][j] has weight i+j.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pp[i][j] = r_s1_a[i] & r_s1_b[j];
      end
    end
  end

  // Dadda reduction: heights 4 -> 3 (first layer), 3 -> 2 (second layer), then a carry-propagate add.
  logic w_h1s, w_h1c, w_h2s, w_h2c, w_h3s, w_h3c;
  logic w_f1s, w_f1c, w_f2s, w_f2c, w_f3s, w_f3c;
  logic [7:0] w_row_x, w_row_y;

  assign w_h1s = w_pp[0][3] ^ w_pp[1][2];
  assign w_h1c = w_pp[0][3] & w_pp[1][2];
  assign w_h2s = w_pp[1][3] ^ w_pp[2][2];
  assign w_h2c = w_pp[1][3] & w_pp[2][2];

  assign w_h3s = w_pp[0][2] ^ w_pp[1][1];
  assign w_h3c = w_pp[0][2] & w_pp[1][1];
  assign w_f1s = w_h1s ^ w_pp[2][1] ^ w_pp[3][0];
  assign w_f1c = (w_h1s & w_pp[2][1]) | (w_h1s & w_pp[3][0]) | (w_pp[2][1] & w_pp[3][0]);
  assign w_f2s = w_h2s ^ w_pp[3][1] ^ w_h1c;
  assign w_f2c = (w_h2s & w_pp[3][1]) | (w_h2s & w_h1c) | (w_pp[3][1] & w_h1c);
  assign w_f3s = w_pp[2][3] ^ w_pp[3][2] ^ w_h2c;
  assign w_f3c = (w_pp[2][3] & w_pp[3][2]) | (w_pp[2][3] & w_h2c) | (w_pp[3][2] & w_h2c);

  assign w_row_x = {1'b0, w_pp[3][3], w_f3s, w_f2s, w_f1s, w_h3s, w_pp[0][1], w_pp[0][0]};
  assign w_row_y = {1'b0, w_f3c, w_f2c, w_f1c, w_h3c, w_pp[2][0], w_pp[1][0], 1'b0};
  assign w_prod  = w_row_x + w_row_y;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_cnt   <= '0;
      r_s1_v  <= 1'b0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
      r_s2_v  <= 1'b0;
      r_s2_p  <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_a <= a;
        r_s1_b <= b;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_p <= w_prod;
      end
      if (r_s2_v) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end

      case (r_state)
        StIdle: begin
          if (start) begin
            r_len   <= len;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_state <= (len == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state <= StFlush;
            end
          end
        end
        StFlush: begin
          if (!r_s1_v && !r_s2_v) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Scenario bench for dadda_mac_accumulator: a 12-bit and an 8-bit accumulator instance share the
// operand stream; expected sums are queued as bursts are driven and popped when out_valid rises.
module tb_dadda_mac_accumulator;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start12 = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] len = '0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       out_ready = 1'b0;

  logic        in_ready12, out_valid12, overflow12, busy12;
  logic [11:0] acc12;
  logic        in_ready8, out_valid8, overflow8, busy8;
  logic [7:0]  acc8;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   pa[16];
  int   pb[16];
  int   n_checks = 0;
  int   n_err = 0;
  int   hs12 = 0;
  int   hs8 = 0;
  int   rdy12_cyc = 0;

  always #5 clk = ~clk;

  dadda_mac_accumulator #(.ACC_W(12), .CNT_W(4)) u_dut12 (
    .clk(clk), .clear(clear), .start(start12), .len(len), .in_valid(in_valid),
    .in_ready(in_ready12), .a(a), .b(b), .out_valid(out_valid12), .out_ready(out_ready),
    .acc_out(acc12), .overflow(overflow12), .busy(busy12)
  );

  dadda_mac_accumulator #(.ACC_W(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .clear(clear), .start(start8), .len(len), .in_valid(in_valid),
    .in_ready(in_ready8), .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready),
    .acc_out(acc8), .overflow(overflow8), .busy(busy8)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready12) hs12 <= hs12 + 1;
    if (in_valid && in_ready8) hs8 <= hs8 + 1;
    if (in_ready12) rdy12_cyc <= rdy12_cyc + 1;
  end

  // Runs one burst on the selected instance (sel=1 -> 8-bit), pushes the expected result and
  // returns with out_valid high (sampled at the negedge), or with tmo set.
  task automatic drive_burst(input bit sel, input int n, input int gap,
                             output int lat, output bit tmo);
    int  sum = 0;
    int  i = 0;
    int  cyc = 0;
    int  w;
    bit  hs;
    exp_t e;
    tmo = 1'b0;
    lat = 0;
    w = sel ? 8 : 12;
    len = 4'(n);
    if (sel) start8 = 1'b1;
    else start12 = 1'b1;
    @(posedge clk) #1;
    start8 = 1'b0;
    start12 = 1'b0;
    while (i < n && cyc < 200) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk) #1;
      end
      in_valid = 1'b1;
      a = 4'(pa[i]);
      b = 4'(pb[i]);
      @(negedge clk);
      hs = sel ? in_ready8 : in_ready12;
      @(posedge clk) #1;
      if (hs) begin
        sum += pa[i] * pb[i];
        i++;
      end
      cyc++;
    end
    e.acc = sum % (1 << w);
    e.ovf = (sum >= (1 << w));
    sb.push_back(e);
    // Junk beats offered while flushing must not be taken.
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd15;
    tmo = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sel ? out_valid8 : out_valid12) begin
        tmo = 1'b0;
        lat = k;
        break;
      end
      @(posedge clk) #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready12, out_valid12, overflow12, busy12} !== 4'b0 || acc12 !== 12'd0) begin
      n_err++;
      $display("FAIL reset12: rdy/ov/ovf/busy=%b acc=%0d, want 0000 acc=0",
               {in_ready12, out_valid12, overflow12, busy12}, acc12);
    end
    n_checks++;
    if ({in_ready8, out_valid8, overflow8, busy8} !== 4'b0 || acc8 !== 8'd0) begin
      n_err++;
      $display("FAIL reset8: rdy/ov/ovf/busy=%b acc=%0d, want 0000 acc=0",
               {in_ready8, out_valid8, overflow8, busy8}, acc8);
    end
    @(posedge clk) #1;
    clear = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_single();
    int lat;
    bit tmo;
    exp_t e;
    pa[0] = 15;
    pb[0] = 15;
    drive_burst(1'b0, 1, 0, lat, tmo);
    n_checks++;
    if (tmo || lat !== 3) begin
      n_err++;
      $display("FAIL t1_latency: tmo=%0d lat=%0d, want tmo=0 lat=3", tmo, lat);
    end
    e = sb.pop_front();
    n_checks++;
    if (int'(acc12) !== e.acc || overflow12 !== e.ovf) begin
      n_err++;
      $display("FAIL t1_acc: acc=%0d ovf=%b, want acc=%0d ovf=%b", acc12, overflow12, e.acc, e.ovf);
    end
    handshake();
    @(negedge clk);
    n_checks++;
    if (busy12 !== 1'b0 || out_valid12 !== 1'b0) begin
      n_err++;
      $display("FAIL t1_idle: busy=%b ov=%b, want 0 0", busy12, out_valid12);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_gaps_and_hold();
    int lat;
    int hs0;
    bit tmo;
    bit held;
    exp_t e;
    pa[0] = 1; pb[0] = 2;
    pa[1] = 3; pb[1] = 4;
    pa[2] = 5; pb[2] = 6;
    pa[3] = 7; pb[3] = 8;
    hs0 = hs12;
    drive_burst(1'b0, 4, 1, lat, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || lat !== 3) begin
      n_err++;
      $display("FAIL t2_latency: tmo=%0d lat=%0d, want tmo=0 lat=3", tmo, lat);
    end
    n_checks++;
    if (hs12 - hs0 !== 4) begin
      n_err++;
      $display("FAIL t2_beats: accepted=%0d, want 4", hs12 - hs0);
    end
    n_checks++;
    if (int'(acc12) !== e.acc || overflow12 !== e.ovf) begin
      n_err++;
      $display("FAIL t2_acc: acc=%0d ovf=%b, want acc=%0d ovf=%b", acc12, overflow12, e.acc, e.ovf);
    end
    // Hold in DONE with start pulsed: nothing may change.
    held = 1'b1;
    @(posedge clk) #1;
    for (int k = 0; k < 5; k++) begin
      start12 = (k == 2);
      len = 4'd3;
      @(negedge clk);
      if (out_valid12 !== 1'b1 || int'(acc12) !== e.acc) held = 1'b0;
      @(posedge clk) #1;
    end
    start12 = 1'b0;
    n_checks++;
    if (!held) begin
      n_err++;
      $display("FAIL t3_hold: ov=%b acc=%0d, want ov=1 acc=%0d", out_valid12, acc12, e.acc);
    end
    start12 = 1'b1;
    handshake();
    start12 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy12 !== 1'b0 || out_valid12 !== 1'b0) begin
      n_err++;
      $display("FAIL t3_idle_after_hs: busy=%b ov=%b, want 0 0", busy12, out_valid12);
    end
    @(posedge clk) #1;
    @(negedge clk);
    n_checks++;
    if (busy12 !== 1'b0) begin
      n_err++;
      $display("FAIL t3_no_new_burst: busy=%b, want 0", busy12);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_overflow();
    int lat;
    bit tmo;
    exp_t e;
    pa[0] = 15; pb[0] = 15;
    pa[1] = 15; pb[1] = 15;
    drive_burst(1'b1, 2, 0, lat, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || int'(acc8) !== e.acc || overflow8 !== e.ovf || e.acc !== 194) begin
      n_err++;
      $display("FAIL t4_wrap: tmo=%0d acc=%0d ovf=%b, want acc=%0d ovf=%b",
               tmo, acc8, overflow8, e.acc, e.ovf);
    end
    handshake();
    pa[0] = 1; pb[0] = 1;
    drive_burst(1'b1, 1, 0, lat, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || int'(acc8) !== e.acc || overflow8 !== e.ovf) begin
      n_err++;
      $display("FAIL t4_next_burst: tmo=%0d acc=%0d ovf=%b, want acc=%0d ovf=%b",
               tmo, acc8, overflow8, e.acc, e.ovf);
    end
    handshake();
  endtask

  task automatic test_len_zero();
    int lat;
    int r0;
    bit tmo;
    exp_t e;
    r0 = rdy12_cyc;
    drive_burst(1'b0, 0, 0, lat, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || lat !== 0 || int'(acc12) !== e.acc) begin
      n_err++;
      $display("FAIL t5_len0: tmo=%0d lat=%0d acc=%0d, want lat=0 acc=%0d", tmo, lat, acc12, e.acc);
    end
    handshake();
    n_checks++;
    if (rdy12_cyc !== r0) begin
      n_err++;
      $display("FAIL t5_in_ready: ready cycles=%0d, want 0", rdy12_cyc - r0);
    end
  endtask

  task automatic test_async_clear();
    int lat;
    bit tmo;
    exp_t e;
    len = 4'd4;
    start12 = 1'b1;
    @(posedge clk) #1;
    start12 = 1'b0;
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd9;
    repeat (2) @(posedge clk) #1;
    in_valid = 1'b0;
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if ({in_ready12, out_valid12, overflow12, busy12} !== 4'b0 || acc12 !== 12'd0) begin
      n_err++;
      $display("FAIL t6_async_clear: rdy/ov/ovf/busy=%b acc=%0d, want 0000 acc=0",
               {in_ready12, out_valid12, overflow12, busy12}, acc12);
    end
    @(posedge clk) #1;
    clear = 1'b1;
    @(posedge clk) #1;
    pa[0] = 2; pb[0] = 3;
    pa[1] = 4; pb[1] = 5;
    drive_burst(1'b0, 2, 0, lat, tmo);
    e = sb.pop_front();
    n_checks++;
    if (tmo || int'(acc12) !== e.acc || e.acc !== 26 || overflow12 !== 1'b0) begin
      n_err++;
      $display("FAIL t6_after_clear: tmo=%0d acc=%0d ovf=%b, want acc=26 ovf=0",
               tmo, acc12, overflow12);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps_and_hold();
    test_overflow();
    test_len_zero();
    test_async_clear();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
